delay_tap_checker: RTL and testbench

DELAY_TAP_CHECKER -- requirements
Module: delay_tap_checker

---
 rtl/delay_tap_checker_pkg.sv | 16 +
 rtl/delay_tap_checker.sv | 172 +++++++++++++++++
 tb/tb_delay_tap_checker.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_tap_checker_pkg.sv
// Shared types and defaults for the delay-line tap sweep controller.
package delay_tap_checker_pkg;

  localparam int LAT_OFFSET_DEFAULT = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SETUP,
    S_INJECT,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/delay_tap_checker.sv
// Sweeps the taps of an external dynamic delay line, injects a single pulse per
// tap, measures its latency and reports failing taps.
module delay_tap_checker
  import delay_tap_checker_pkg::*;
#(
  parameter int LENGTH     = 1024,
  parameter int SEL_W      = $clog2(LENGTH),
  parameter int LAT_OFFSET = LAT_OFFSET_DEFAULT,
  parameter int CNT_W      = $clog2(LENGTH + LAT_OFFSET + 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SEL_W-1:0] tap_first,
  input  logic [SEL_W-1:0] tap_last,
  output logic [SEL_W-1:0] dd_sel,
  output logic             dd_in,
  output logic             dd_ena,
  input  logic             dd_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SEL_W:0]   err_cnt,
  output logic [SEL_W-1:0] first_bad,
  output logic             first_bad_vld,
  output logic [CNT_W-1:0] meas_lat,
  output logic             meas_vld,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(LENGTH + LAT_OFFSET - 1);
  localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(LENGTH + LAT_OFFSET + 4);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [SEL_W-1:0] SEL_ONE    = SEL_W'(1);
  localparam logic [SEL_W:0]   ERR_ONE    = (SEL_W + 1)'(1);

  state_t           state;
  logic [SEL_W-1:0] tap;
  logic [SEL_W-1:0] last_q;
  logic [CNT_W-1:0] cnt;
  logic             timed_out;

  logic [CNT_W-1:0] meas_exp;
  logic             tap_fail;
  logic [SEL_W:0]   err_inc;
  logic             at_last;

  assign dbg_state = state;

  always_comb begin
    meas_exp = CNT_W'(tap) + CNT_W'(LAT_OFFSET);
    tap_fail = timed_out || (meas_lat != meas_exp);
    err_inc  = (err_cnt == '1) ? err_cnt : err_cnt + ERR_ONE;
    at_last  = (tap == last_q);
  end

  // Handshake: start is a one-cycle request accepted only in IDLE without abort;
  // busy stays high from acceptance until the cycle done pulses, and pass/err_cnt/
  // first_bad are stable from that done pulse until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      tap           <= '0;
      last_q        <= '0;
      cnt           <= '0;
      timed_out     <= 1'b0;
      dd_sel        <= '0;
      dd_in         <= 1'b0;
      dd_ena        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_bad     <= '0;
      first_bad_vld <= 1'b0;
      meas_lat      <= '0;
      meas_vld      <= 1'b0;
    end else begin
      done     <= 1'b0;
      meas_vld <= 1'b0;
      dd_in    <= 1'b0;
      if (abort && state != S_IDLE && state != S_DONE) begin
        state <= S_DONE;
        done  <= 1'b1;
        pass  <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              tap           <= tap_first;
              last_q        <= tap_last;
              cnt           <= '0;
              err_cnt       <= '0;
              first_bad_vld <= 1'b0;
              pass          <= 1'b0;
              dd_ena        <= 1'b1;
              if (tap_first > tap_last) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_FLUSH;
                busy  <= 1'b1;
              end
            end
          end
          S_FLUSH: begin
            if (cnt == FLUSH_LAST) begin
              state  <= S_SETUP;
              dd_sel <= tap;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_SETUP: begin
            state <= S_INJECT;
            dd_in <= 1'b1;
          end
          S_INJECT: begin
            state     <= S_WAIT;
            cnt       <= '0;
            timed_out <= 1'b0;
          end
          S_WAIT: begin
            cnt <= cnt + CNT_ONE;
            if (dd_out) begin
              state    <= S_CHECK;
              meas_lat <= cnt + CNT_ONE;
              meas_vld <= 1'b1;
            end else if (cnt + CNT_ONE == TIMEOUT) begin
              state     <= S_CHECK;
              meas_lat  <= TIMEOUT;
              meas_vld  <= 1'b1;
              timed_out <= 1'b1;
            end
          end
          S_CHECK: begin
            if (tap_fail) begin
              err_cnt <= err_inc;
              if (!first_bad_vld) begin
                first_bad     <= tap;
                first_bad_vld <= 1'b1;
              end
            end
            // A failed tap may leave its pulse in the line, so re-flush before the next one.
            if (at_last) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (err_cnt == '0) && !tap_fail;
            end else if (tap_fail) begin
              state <= S_FLUSH;
              tap   <= tap + SEL_ONE;
              cnt   <= '0;
            end else begin
              state  <= S_SETUP;
              tap    <= tap + SEL_ONE;
              dd_sel <= tap + SEL_ONE;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            dd_ena <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_tap_checker.sv
// Bench for delay_tap_checker: behavioural 16-tap delay line with optional faults
// and per-sweep expectations derived from the tap latency rules.
module tb_delay_tap_checker;
  import delay_tap_checker_pkg::*;

  localparam int LENGTH    = 16;
  localparam int SEL_W     = 4;
  localparam int CNT_W     = $clog2(LENGTH + 1 + 8);
  localparam int FLUSH_LEN = LENGTH + 1;
  localparam int TIMEOUT   = LENGTH + 1 + 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [SEL_W-1:0] tap_first = '0;
  logic [SEL_W-1:0] tap_last = '0;
  logic [SEL_W-1:0] dd_sel;
  logic             dd_in;
  logic             dd_ena;
  logic             dd_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SEL_W:0]   err_cnt;
  logic [SEL_W-1:0] first_bad;
  logic             first_bad_vld;
  logic [CNT_W-1:0] meas_lat;
  logic             meas_vld;
  state_t           dbg_state;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_lat;
  int inj_q[$];
  int cyc_now = 0;
  int inj_cnt = 0;
  int meas_seen = 0;
  bit chk_meas = 1'b1;
  bit stuck = 1'b0;
  int fault_tap = -1;
  int exp_err;
  int exp_fb;
  bit exp_fb_vld;
  logic [LENGTH:0] sr;

  delay_tap_checker #(.LENGTH(LENGTH)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tap_first(tap_first), .tap_last(tap_last),
    .dd_sel(dd_sel), .dd_in(dd_in), .dd_ena(dd_ena), .dd_out(dd_out),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_bad(first_bad), .first_bad_vld(first_bad_vld),
    .meas_lat(meas_lat), .meas_vld(meas_vld), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Delay line model: tap s normally delays by s+1 clocks
  always @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else if (dd_ena) sr <= {sr[LENGTH-1:0], dd_in};
  end

  always_comb begin
    dd_out = 1'b0;
    if (!stuck) begin
      if (int'(dd_sel) == fault_tap) dd_out = sr[int'(dd_sel) + 1];
      else dd_out = sr[dd_sel];
    end
  end

  function automatic int line_lat(input int sel);
    return (sel == fault_tap) ? sel + 2 : sel + 1;
  endfunction

  // Scoreboard: expected latency per meas_vld pulse, injection log
  always @(negedge clk) begin
    if (!rst) begin
      if (dd_in === 1'b1) begin
        inj_cnt++;
        inj_q.push_back(cyc_now);
      end
      if (meas_vld === 1'b1) begin
        meas_seen++;
        if (exp_q.size() != 0) begin
          exp_lat = exp_q.pop_front();
          checks++;
          if (meas_lat !== exp_lat) begin
            errors++;
            $display("FAIL meas_lat got %0d want %0d (dd_sel %0d)", meas_lat, exp_lat, dd_sel);
          end
        end else if (chk_meas) begin
          checks++;
          errors++;
          $display("FAIL meas_unexpected got pulse with meas_lat %0d want none", meas_lat);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic plan_sweep(input int f, input int l);
    exp_q.delete();
    exp_err = 0;
    exp_fb = 0;
    exp_fb_vld = 1'b0;
    meas_seen = 0;
    for (int t = f; t <= l; t++) begin
      if (stuck || line_lat(t) != t + 1) begin
        exp_err++;
        if (!exp_fb_vld) begin
          exp_fb = t;
          exp_fb_vld = 1'b1;
        end
      end
      if (!stuck) exp_q.push_back(CNT_W'(line_lat(t)));
    end
  endtask

  task automatic do_start(input int f, input int l);
    @(negedge clk);
    tap_first = SEL_W'(f);
    tap_last = SEL_W'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    ok = (done === 1'b1);
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_state got %0d want %0d", dbg_state, S_IDLE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL rst_pass got %0b want 0", pass); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
    checks++; if (dd_ena !== 1'b0 || dd_in !== 1'b0 || dd_sel !== '0) begin errors++; $display("FAIL rst_dd got ena %0b in %0b sel %0d want 0 0 0", dd_ena, dd_in, dd_sel); end
    checks++; if (first_bad !== '0 || first_bad_vld !== 1'b0) begin errors++; $display("FAIL rst_first_bad got %0d/%0b want 0/0", first_bad, first_bad_vld); end
    checks++; if (meas_lat !== '0 || meas_vld !== 1'b0) begin errors++; $display("FAIL rst_meas got %0d/%0b want 0/0", meas_lat, meas_vld); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dd_ena !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_rst got ena %0b busy %0b want 0 0", dd_ena, busy); end
  endtask

  task automatic test_good_sweep();
    bit ok; int cyc;
    fault_tap = -1; stuck = 1'b0; chk_meas = 1'b1;
    plan_sweep(0, 15);
    do_start(0, 15);
    checks++; if (busy !== 1'b1 || dd_ena !== 1'b1) begin errors++; $display("FAIL good_busy got busy %0b ena %0b want 1 1", busy, dd_ena); end
    wait_done(2000, ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL good_done_timeout got %0d cycles want done", cyc); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL good_pass got %0b want 1", pass); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL good_err_cnt got %0d want 0", err_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_at_done got %0b want 0", busy); end
    checks++; if (meas_seen != 16 || exp_q.size() != 0) begin errors++; $display("FAIL good_meas_count got %0d left %0d want 16 left 0", meas_seen, exp_q.size()); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || pass !== 1'b1) begin errors++; $display("FAIL good_done_pulse got done %0b pass %0b want 0 1", done, pass); end
  endtask

  task automatic test_late_tap();
    bit ok; int cyc;
    fault_tap = 5; stuck = 1'b0; chk_meas = 1'b1;
    plan_sweep(0, 15);
    do_start(0, 15);
    wait_done(2000, ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL late_done_timeout got %0d cycles want done", cyc); end
    checks++; if (err_cnt !== (SEL_W+1)'(exp_err)) begin errors++; $display("FAIL late_err_cnt got %0d want %0d", err_cnt, exp_err); end
    checks++; if (first_bad_vld !== 1'b1 || first_bad !== SEL_W'(exp_fb)) begin errors++; $display("FAIL late_first_bad got %0d/%0b want %0d/1", first_bad, first_bad_vld, exp_fb); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL late_pass got %0b want 0", pass); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL late_meas_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_stuck();
    bit ok; int cyc;
    fault_tap = -1; stuck = 1'b1; chk_meas = 1'b0;
    plan_sweep(3, 4);
    inj_q.delete();
    do_start(3, 4);
    wait_done(2000, ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL stuck_done_timeout got %0d cycles want done", cyc); end
    checks++; if (err_cnt !== (SEL_W+1)'(exp_err)) begin errors++; $display("FAIL stuck_err_cnt got %0d want %0d", err_cnt, exp_err); end
    checks++; if (first_bad_vld !== 1'b1 || first_bad !== SEL_W'(exp_fb)) begin errors++; $display("FAIL stuck_first_bad got %0d/%0b want %0d/1", first_bad, first_bad_vld, exp_fb); end
    checks++; if (meas_seen != 2) begin errors++; $display("FAIL stuck_meas_count got %0d want 2", meas_seen); end
    checks++;
    if (inj_q.size() != 2) begin
      errors++; $display("FAIL stuck_inject_count got %0d want 2", inj_q.size());
    end else if (inj_q[1] - inj_q[0] < TIMEOUT + FLUSH_LEN) begin
      errors++; $display("FAIL stuck_flush_gap got %0d want >= %0d", inj_q[1] - inj_q[0], TIMEOUT + FLUSH_LEN);
    end
    stuck = 1'b0; chk_meas = 1'b1;
  endtask

  task automatic test_reversed();
    bit ok; int cyc; int c0;
    exp_q.delete();
    c0 = inj_cnt;
    do_start(9, 4);
    wait_done(3, ok, cyc);
    checks++; if (!ok || cyc > 1) begin errors++; $display("FAIL rev_done_latency got ok %0b cyc %0d want done within 2 clocks", ok, cyc); end
    checks++; if (pass !== 1'b0 || err_cnt !== '0) begin errors++; $display("FAIL rev_result got pass %0b err %0d want 0 0", pass, err_cnt); end
    checks++; if (first_bad_vld !== 1'b0) begin errors++; $display("FAIL rev_first_bad_vld got %0b want 0", first_bad_vld); end
    repeat (3) @(negedge clk);
    checks++; if (inj_cnt != c0) begin errors++; $display("FAIL rev_inject got %0d pulses want 0", inj_cnt - c0); end
  endtask

  task automatic test_abort();
    bit ok; int cyc; int n;
    fault_tap = -1; stuck = 1'b0; chk_meas = 1'b1;
    plan_sweep(0, 15);
    do_start(0, 15);
    n = 0;
    while (!(dd_in === 1'b1 && dd_sel === SEL_W'(7)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 2000) begin errors++; $display("FAIL abort_reach_tap7 got %0d cycles want inject at tap 7", n); end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_result got done %0b pass %0b busy %0b want 1 0 0", done, pass, busy); end
    checks++; if (err_cnt !== '0 || meas_seen != 7) begin errors++; $display("FAIL abort_partial got err %0d meas %0d want 0 7", err_cnt, meas_seen); end
    plan_sweep(0, 15);
    do_start(0, 15);
    wait_done(2000, ok, cyc);
    checks++; if (!ok || pass !== 1'b1 || err_cnt !== '0) begin errors++; $display("FAIL abort_rerun got ok %0b pass %0b err %0d want 1 1 0", ok, pass, err_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_rerun_meas_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n; int c0;
    fault_tap = -1; stuck = 1'b0; chk_meas = 1'b1;
    plan_sweep(0, 15);
    do_start(0, 15);
    n = 0;
    while (!(dd_in === 1'b1 && dd_sel === SEL_W'(3)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 2000) begin errors++; $display("FAIL rstmid_reach_tap3 got %0d cycles want inject at tap 3", n); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (dbg_state !== S_IDLE || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got state %0d busy %0b done %0b want %0d 0 0", dbg_state, busy, done, S_IDLE); end
    checks++; if (dd_ena !== 1'b0 || dd_in !== 1'b0 || dd_sel !== '0) begin errors++; $display("FAIL rstmid_dd got ena %0b in %0b sel %0d want 0 0 0", dd_ena, dd_in, dd_sel); end
    checks++; if (err_cnt !== '0 || first_bad_vld !== 1'b0 || meas_lat !== '0 || pass !== 1'b0) begin errors++; $display("FAIL rstmid_results got err %0d fbv %0b lat %0d pass %0b want 0 0 0 0", err_cnt, first_bad_vld, meas_lat, pass); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    c0 = inj_cnt;
    repeat (40) @(negedge clk);
    checks++; if (inj_cnt != c0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %0d pulses busy %0b want 0 0", inj_cnt - c0, busy); end
  endtask

  task automatic test_random();
    bit ok; int cyc; int f; int l;
    stuck = 1'b0; chk_meas = 1'b1;
    for (int it = 0; it < 4; it++) begin
      f = $urandom_range(0, 15);
      l = $urandom_range(f, 15);
      fault_tap = ($urandom_range(0, 1) == 1) ? $urandom_range(f, l) : -1;
      plan_sweep(f, l);
      do_start(f, l);
      wait_done(3000, ok, cyc);
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_done_timeout got %0d cycles want done", it, cyc); end
      checks++; if (err_cnt !== (SEL_W+1)'(exp_err) || pass !== (exp_err == 0)) begin errors++; $display("FAIL rnd%0d_result taps %0d..%0d fault %0d got err %0d pass %0b want %0d %0b", it, f, l, fault_tap, err_cnt, pass, exp_err, exp_err == 0); end
      checks++; if (first_bad_vld !== exp_fb_vld || (exp_fb_vld && first_bad !== SEL_W'(exp_fb))) begin errors++; $display("FAIL rnd%0d_first_bad got %0d/%0b want %0d/%0b", it, first_bad, first_bad_vld, exp_fb, exp_fb_vld); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd%0d_meas_left got %0d want 0", it, exp_q.size()); end
    end
    fault_tap = -1;
  endtask

  initial begin
    test_reset();
    test_good_sweep();
    test_late_tap();
    test_stuck();
    test_reversed();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
